// File: rtl/cpu_input_conditioner.sv
// cpu_input_conditioner: synchronizes and debounces raw board inputs ahead of the input PIO.
// Each bit has its own 2-flop synchronizer and counter, and a new level is accepted only
// after it has held for DEBOUNCE_CYCLES consecutive synchronized samples.
// Ports:
//   clk           - single clock, all state updates on the rising edge
//   reset         - asynchronous, active-high reset
//   raw_in        - asynchronous switch/button inputs
//   debounced_out - registered stable level per bit (drives PIO in_port)
//   rise_pulse    - one-cycle pulse per bit on an accepted 0->1 transition
//   fall_pulse    - one-cycle pulse per bit on an accepted 1->0 transition
//   changed       - one-cycle pulse when any bit of debounced_out changes
module cpu_input_conditioner #(
  parameter int unsigned      WIDTH           = 8,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] mismatch_c;
  logic [WIDTH-1:0] accept_c;

  // Two-flop synchronizer; nothing downstream looks at sync1 or raw_in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // A bit is accepted when it still disagrees after the counter has saturated.
  always_comb begin
    mismatch_c = sync2 ^ debounced_out;
    accept_c   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      accept_c[i] = mismatch_c[i] && (cnt[i] == CNT_MAX);
    end
  end

  // Per-bit counters: clear on agreement or acceptance, otherwise count up (never past CNT_MAX).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (!mismatch_c[i] || accept_c[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Output level and edge pulses all update on the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debounced_out <= RESET_VALUE;
      rise_pulse    <= '0;
      fall_pulse    <= '0;
      changed       <= 1'b0;
    end else begin
      debounced_out <= debounced_out ^ accept_c;
      rise_pulse    <= accept_c & sync2;
      fall_pulse    <= accept_c & ~sync2;
      changed       <= |accept_c;
    end
  end

endmodule

// File: tb/tb_cpu_input_conditioner.sv
// Scoreboard bench for cpu_input_conditioner with DEBOUNCE_CYCLES=4, WIDTH=8, RESET_VALUE=0.
module tb_cpu_input_conditioner;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] raw_in;
  logic [W-1:0] debounced_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic         changed;

  cpu_input_conditioner #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .RESET_VALUE    (8'h00)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_in       (raw_in),
    .debounced_out(debounced_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .changed      (changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  edge_no;
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  exp_t         sbq[$];
  int unsigned  cyc = 0;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_dout = '0;

  // Rising edges seen so far; at a negedge this is the number of the last edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Called right after a drive at a negedge: first capture is the next edge,
  // acceptance comes DEBOUNCE_CYCLES+1 edges after that.
  task automatic expect_change(input logic [W-1:0] d, input logic [W-1:0] r, input logic [W-1:0] f);
    exp_t e;
    e.edge_no = cyc + 1 + D + 1;
    e.dout    = d;
    e.rise    = r;
    e.fall    = f;
    sbq.push_back(e);
  endtask

  task automatic set_raw(input logic [W-1:0] v);
    @(negedge clk);
    raw_in = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals a change.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_dout", 32'(debounced_out), 32'(8'h00));
        check("reset_rise", 32'(rise_pulse), 32'(0));
        check("reset_fall", 32'(fall_pulse), 32'(0));
        check("reset_changed", 32'(changed), 32'(0));
        exp_dout = '0;
      end else if (changed) begin
        if (sbq.size() == 0) begin
          check("unexpected_change_dout", 32'(debounced_out), 32'(exp_dout));
        end else begin
          e = sbq.pop_front();
          check("change_edge", 32'(cyc), 32'(e.edge_no));
          check("change_dout", 32'(debounced_out), 32'(e.dout));
          check("change_rise", 32'(rise_pulse), 32'(e.rise));
          check("change_fall", 32'(fall_pulse), 32'(e.fall));
          exp_dout = e.dout;
        end
      end else begin
        check("idle_rise", 32'(rise_pulse), 32'(0));
        check("idle_fall", 32'(fall_pulse), 32'(0));
        check("stable_dout", 32'(debounced_out), 32'(exp_dout));
        if (sbq.size() != 0 && sbq[0].edge_no <= cyc) begin
          check("changed_at_expected_edge", 32'(changed), 32'(1));
          e = sbq.pop_front();
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset  = 1'b1;
    raw_in = '0;
    idle(3);
    #2 reset = 1'b0;
    idle(4);

    // Single bit rise, full latency, pulse lasts one cycle.
    set_raw(8'h01); expect_change(8'h01, 8'h01, 8'h00);
    idle(8);
    set_raw(8'h00); expect_change(8'h00, 8'h00, 8'h01);
    idle(8);

    // Three-cycle glitch is rejected; a following valid rise needs full latency again.
    set_raw(8'h01); idle(2); set_raw(8'h00);
    idle(3);
    set_raw(8'h01); expect_change(8'h01, 8'h01, 8'h00);
    idle(8);

    // All bits together: rise on the seven that were low, then fall on all eight.
    set_raw(8'hFF); expect_change(8'hFF, 8'hFE, 8'h00);
    idle(8);
    set_raw(8'h00); expect_change(8'h00, 8'h00, 8'hFF);
    idle(8);

    // Staggered bits keep independent counters: separate pulses two cycles apart.
    set_raw(8'h02); expect_change(8'h02, 8'h02, 8'h00);
    idle(1);
    set_raw(8'h0A); expect_change(8'h0A, 8'h08, 8'h00);
    idle(8);
    set_raw(8'h00); expect_change(8'h00, 8'h00, 8'h0A);
    idle(8);

    // Reset mid-count discards the partial count.
    set_raw(8'h10);
    idle(4);
    #2 reset = 1'b1;
    idle(2);
    #2 reset = 1'b0;
    expect_change(8'h10, 8'h10, 8'h00);
    idle(8);

    // Bouncing bit7: ten two-cycle runs, then held high -> exactly one rise.
    for (int k = 0; k < 5; k++) begin
      set_raw(8'h90); idle(1);
      set_raw(8'h10); idle(1);
    end
    set_raw(8'h90); expect_change(8'h90, 8'h80, 8'h00);
    idle(8);

    for (int i = 0; i < 60 && sbq.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'(0));
    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_input_conditioner.md
CPU_INPUT_CONDITIONER -- requirements
Module: cpu_input_conditioner

Purpose: conditions raw board inputs (switches/buttons) upstream of the 8-bit input PIO; debounced_out drives the PIO in_port.

Interface
REQ-001 Parameter WIDTH, default 8: number of independent input bits.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive mismatch cycles required to accept a new level; legal range 2..2^20.
REQ-003 Parameter RESET_VALUE, default 0 (WIDTH bits): value loaded into debounced_out on reset.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 raw_in  input  WIDTH: asynchronous external inputs, no timing relation to clk.
REQ-007 debounced_out  output  WIDTH: registered, stable, debounced level per bit.
REQ-008 rise_pulse  output  WIDTH: registered one-cycle pulse per bit on an accepted 0->1 transition.
REQ-009 fall_pulse  output  WIDTH: registered one-cycle pulse per bit on an accepted 1->0 transition.
REQ-010 changed  output  1: registered; high for one cycle when any bit of debounced_out changes.

Function
REQ-011 Each bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic uses it.
REQ-012 Each bit SHALL own an independent counter of width ceil(log2(DEBOUNCE_CYCLES)); bits never share state.
REQ-013 Per bit, on an edge where sync2 == debounced_out bit: counter <= 0, no output change.
REQ-014 Per bit, on an edge where sync2 != debounced_out bit and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
REQ-015 Per bit, on an edge where sync2 != debounced_out bit and counter == DEBOUNCE_CYCLES-1: debounced_out bit <= sync2, counter <= 0.
REQ-016 Latency: a raw_in level first captured into sync1 at edge E0 and held SHALL appear on debounced_out at edge E0+DEBOUNCE_CYCLES+1, not earlier.
REQ-017 Glitch rejection: a mismatch lasting fewer than DEBOUNCE_CYCLES consecutive sync2 cycles SHALL leave debounced_out unchanged and clear the counter.
REQ-018 Counter SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap-around).
REQ-019 rise_pulse/fall_pulse bit SHALL assert on the same edge that debounced_out updates, for exactly one cycle, and is 0 otherwise.
REQ-020 rise_pulse and fall_pulse for the same bit SHALL never be high together.
REQ-021 changed SHALL equal OR of all rise_pulse and fall_pulse bits, asserted in the same cycle as those pulses.
REQ-022 Simultaneous accepted transitions on several bits in one cycle SHALL all be reflected in the same cycle's pulses and debounced_out.
REQ-023 A bit changing while another bit's counter runs SHALL not affect that other counter.

Reset
REQ-024 While reset is high: sync1, sync2 <= 0; counters <= 0; debounced_out <= RESET_VALUE; rise_pulse, fall_pulse <= 0; changed <= 0.
REQ-025 Reset assertion SHALL take effect immediately without clk; reset mid-count SHALL discard partial counts.
REQ-026 First edge after reset deassertion: normal operation resumes; a raw_in differing from RESET_VALUE SHALL then require the full REQ-016 latency, no pulse before it.

Verification (DEBOUNCE_CYCLES=4, WIDTH=8, RESET_VALUE=0)
REQ-027 raw_in 0x00->0x01 held, first sampled at edge E0 -> debounced_out=0x01, rise_pulse=0x01, changed=1 at edge E0+5 only; all pulses 0 at E0+6.
REQ-028 raw_in bit0 high for 3 cycles then low -> debounced_out stays 0x00, no pulses, bit0 counter returns to 0.
REQ-029 debounced_out=0xFF, raw_in -> 0x00 held -> debounced_out=0x00, fall_pulse=0xFF, rise_pulse=0x00, changed=1 in one cycle.
REQ-030 bit3 raised 2 cycles after bit1, both held -> rise_pulse=0x02 and 0x08 in separate cycles two apart; changed high in both.
REQ-031 reset pulsed mid-count (counter=2) with raw_in=0x10 held -> outputs 0, then debounced_out=0x10 exactly DEBOUNCE_CYCLES+1 edges after first post-reset sample.
REQ-032 Bouncing raw_in bit7 (toggle every 2 cycles for 20 cycles, then high) -> exactly one rise_pulse on bit7, no fall_pulse.
